// File: rtl/distributed_moesi.sv
// distributed_moesi: single-line three-node MOESI directory updating all node states per request
module distributed_moesi (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_proc,
  input  logic       read_req,
  input  logic       write_req,
  output logic [2:0] state_p0,
  output logic [2:0] state_p1,
  output logic [2:0] state_p2
);
  localparam logic [2:0] I = 3'b000, S = 3'b001, E = 3'b010, O = 3'b011, M = 3'b100;
  logic [2:0] st [3];
  logic [2:0] nxt [3];
  logic [2:0] st_r, pres, sel;
  logic       valid, others;
  assign valid  = (read_req | write_req) && req_proc != 2'd3;
  assign sel    = 3'(1) << req_proc;
  assign pres   = {st[2] != I, st[1] != I, st[0] != I};
  assign others = |(pres & ~sel);
  assign st_r   = req_proc == 2'd0 ? st[0] : req_proc == 2'd1 ? st[1] : st[2];
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      nxt[i] = st[i];
      if (valid)
        nxt[i] = sel[i] ? (write_req ? M : st[i] == I ? (others ? S : E) : st[i])
                        : (write_req ? I : st_r != I ? st[i] : st[i] == M ? O : st[i] == E ? S : st[i]);
    end
  end
  always_ff @(posedge clk)
    if (reset) st <= '{default: I};
    else st <= nxt;
  assign state_p0 = st[0];
  assign state_p1 = st[1];
  assign state_p2 = st[2];
endmodule

// File: tb/tb_distributed_moesi.sv
// tb_distributed_moesi: directed scenario checks of the MOESI directory
module tb_distributed_moesi;
  localparam logic [2:0] I = 3'b000, S = 3'b001, E = 3'b010, O = 3'b011, M = 3'b100;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] req_proc = 2'd0;
  logic       read_req = 1'b0;
  logic       write_req = 1'b0;
  logic [2:0] state_p0, state_p1, state_p2;
  int         passed = 0;
  int         total = 0;

  distributed_moesi dut (
    .clk(clk), .reset(reset), .req_proc(req_proc), .read_req(read_req),
    .write_req(write_req), .state_p0(state_p0), .state_p1(state_p1), .state_p2(state_p2)
  );

  always #5 clk = ~clk;

  task automatic step(input logic rst, input logic [1:0] p, input logic r, input logic w);
    reset = rst;
    req_proc = p;
    read_req = r;
    write_req = w;
    @(posedge clk);
    #1;
    reset = 1'b0;
    read_req = 1'b0;
    write_req = 1'b0;
  endtask

  task automatic test_reset;
    logic [13:0] v [3] = '{
      {1'b1, 2'd0, 1'b0, 1'b0, I, I, I},
      {1'b0, 2'd0, 1'b0, 1'b0, I, I, I},
      {1'b0, 2'd2, 1'b0, 1'b0, I, I, I}
    };
    foreach (v[k]) begin
      step(v[k][13], v[k][12:11], v[k][10], v[k][9]);
      total++;
      if ({state_p0, state_p1, state_p2} !== v[k][8:0])
        $display("FAIL reset step %0d: got %b/%b/%b expected %b/%b/%b", k,
                 state_p0, state_p1, state_p2, v[k][8:6], v[k][5:3], v[k][2:0]);
      else passed++;
    end
  endtask

  task automatic test_migrate;
    logic [13:0] v [9] = '{
      {1'b0, 2'd0, 1'b1, 1'b0, E, I, I},
      {1'b0, 2'd0, 1'b0, 1'b1, M, I, I},
      {1'b0, 2'd0, 1'b0, 1'b1, M, I, I},
      {1'b0, 2'd1, 1'b1, 1'b0, O, S, I},
      {1'b0, 2'd1, 1'b0, 1'b1, I, M, I},
      {1'b0, 2'd2, 1'b1, 1'b0, I, O, S},
      {1'b0, 2'd2, 1'b0, 1'b1, I, I, M},
      {1'b0, 2'd2, 1'b0, 1'b1, I, I, M},
      {1'b0, 2'd2, 1'b1, 1'b0, I, I, M}
    };
    foreach (v[k]) begin
      step(v[k][13], v[k][12:11], v[k][10], v[k][9]);
      total++;
      if ({state_p0, state_p1, state_p2} !== v[k][8:0])
        $display("FAIL migrate step %0d: got %b/%b/%b expected %b/%b/%b", k,
                 state_p0, state_p1, state_p2, v[k][8:6], v[k][5:3], v[k][2:0]);
      else passed++;
    end
  endtask

  task automatic test_shared;
    logic [13:0] v [7] = '{
      {1'b1, 2'd0, 1'b0, 1'b0, I, I, I},
      {1'b0, 2'd0, 1'b1, 1'b0, E, I, I},
      {1'b0, 2'd1, 1'b1, 1'b0, S, S, I},
      {1'b0, 2'd2, 1'b1, 1'b0, S, S, S},
      {1'b0, 2'd1, 1'b1, 1'b0, S, S, S},
      {1'b0, 2'd0, 1'b0, 1'b1, M, I, I},
      {1'b0, 2'd1, 1'b0, 1'b0, M, I, I}
    };
    foreach (v[k]) begin
      step(v[k][13], v[k][12:11], v[k][10], v[k][9]);
      total++;
      if ({state_p0, state_p1, state_p2} !== v[k][8:0])
        $display("FAIL shared step %0d: got %b/%b/%b expected %b/%b/%b", k,
                 state_p0, state_p1, state_p2, v[k][8:6], v[k][5:3], v[k][2:0]);
      else passed++;
    end
  endtask

  task automatic test_owner_write;
    logic [13:0] v [5] = '{
      {1'b0, 2'd1, 1'b1, 1'b0, O, S, I},
      {1'b0, 2'd2, 1'b1, 1'b0, O, S, S},
      {1'b0, 2'd0, 1'b1, 1'b0, O, S, S},
      {1'b0, 2'd2, 1'b0, 1'b1, I, I, M},
      {1'b0, 2'd2, 1'b1, 1'b1, I, I, M}
    };
    foreach (v[k]) begin
      step(v[k][13], v[k][12:11], v[k][10], v[k][9]);
      total++;
      if ({state_p0, state_p1, state_p2} !== v[k][8:0])
        $display("FAIL owner_write step %0d: got %b/%b/%b expected %b/%b/%b", k,
                 state_p0, state_p1, state_p2, v[k][8:6], v[k][5:3], v[k][2:0]);
      else passed++;
    end
  endtask

  task automatic test_corners;
    logic [13:0] v [8] = '{
      {1'b0, 2'd3, 1'b0, 1'b1, I, I, M},
      {1'b0, 2'd3, 1'b1, 1'b0, I, I, M},
      {1'b1, 2'd0, 1'b0, 1'b0, I, I, I},
      {1'b0, 2'd1, 1'b1, 1'b1, I, M, I},
      {1'b0, 2'd1, 1'b1, 1'b1, I, M, I},
      {1'b1, 2'd0, 1'b0, 1'b1, I, I, I},
      {1'b0, 2'd3, 1'b1, 1'b1, I, I, I},
      {1'b0, 2'd2, 1'b1, 1'b0, I, I, E}
    };
    foreach (v[k]) begin
      step(v[k][13], v[k][12:11], v[k][10], v[k][9]);
      total++;
      if ({state_p0, state_p1, state_p2} !== v[k][8:0])
        $display("FAIL corners step %0d: got %b/%b/%b expected %b/%b/%b", k,
                 state_p0, state_p1, state_p2, v[k][8:6], v[k][5:3], v[k][2:0]);
      else passed++;
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset;
    test_migrate;
    test_shared;
    test_owner_write;
    test_corners;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
